// File: rtl/data_mem_pipe_pkg.sv
// Shared encodings for the data memory pipe: access sizes, output-stage state, error counter limit.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package data_mem_pipe_pkg;

  // Access size encodings carried on req_size; 2'b11 is reserved and treated as an error.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Output stage occupancy: EMPTY means no response is being offered.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } pipeState_t;

  // Error counter sticks at this value instead of wrapping.
  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  // Saturating increment for the error counter.
  function automatic logic [15:0] satInc(input logic [15:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replication, load lane select + extension, alignment/size checks.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when strobes are used and when load data is captured.
module mem_lane_align
  import data_mem_pipe_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  byteOfs,
  input  logic        zeroExt,
  input  logic [31:0] storeData,
  input  logic [31:0] memWord,
  output logic [3:0]  byteEn,
  output logic [31:0] laneData,
  output logic [31:0] loadData,
  output logic        misaligned,
  output logic        sizeBad
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Pick the addressed byte and the addressed half from the full memory word.
  assign byteSel = memWord[{byteOfs, 3'b000} +: 8];
  assign halfSel = byteOfs[1] ? memWord[31:16] : memWord[15:0];

  // Store side: replicate the right-aligned data across all lanes so only the strobes
  // need to depend on the offset; also flag misaligned and reserved-size requests.
  always_comb begin
    byteEn     = 4'b0000;
    laneData   = storeData;
    misaligned = 1'b0;
    sizeBad    = 1'b0;
    case (size)
      SZ_BYTE: begin
        byteEn   = 4'b0001 << byteOfs;
        laneData = {4{storeData[7:0]}};
      end
      SZ_HALF: begin
        byteEn     = byteOfs[1] ? 4'b1100 : 4'b0011;
        laneData   = {2{storeData[15:0]}};
        misaligned = byteOfs[0];
      end
      SZ_WORD: begin
        byteEn     = 4'b1111;
        misaligned = (byteOfs != 2'b00);
      end
      default: begin
        sizeBad = 1'b1;
      end
    endcase
  end

  // Load side: right-align the selected lane(s) and sign- or zero-extend to 32 bits.
  always_comb begin
    loadData = 32'd0;
    case (size)
      SZ_BYTE: loadData = {{24{~zeroExt & byteSel[7]}}, byteSel};
      SZ_HALF: loadData = {{16{~zeroExt & halfSel[15]}}, halfSel};
      SZ_WORD: loadData = memWord;
      default: loadData = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Byte-addressed data memory with byte/half/word loads and stores behind a single output register stage.
// Latency: one cycle from request accept to rsp_valid.
// Backpressure: req_ready = !rsp_valid || rsp_ready, so a stalled response blocks new requests; full throughput otherwise.
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [15:0]       err_count
);

  localparam int IDX_W = $clog2(DEPTH);
  // DEPTH expressed at the width of the word index so the range check never wraps.
  localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(DEPTH);

  pipeState_t        state;
  pipeState_t        stateNext;

  logic              accept;
  logic              outOfRange;
  logic              misaligned;
  logic              sizeBad;
  logic              reqErr;
  logic              memWrEn;
  logic [ADDR_W-3:0] wordIdx;
  logic [IDX_W-1:0]  memIdx;
  logic [3:0]        byteEn;
  logic [31:0]       laneData;
  logic [31:0]       memWord;
  logic [31:0]       loadData;

  // Output stage can take a new request when it is empty or its response leaves this cycle.
  assign rsp_valid = (state == FULL);
  assign req_ready = !rsp_valid || rsp_ready;

  // Nothing is accepted while reset is held, so requests in reset neither write nor respond.
  assign accept = req_valid && req_ready && RESET_N;

  // Full word index is checked against DEPTH; only the low bits address the arrays.
  assign wordIdx    = req_addr[ADDR_W-1:2];
  assign memIdx     = req_addr[IDX_W+1:2];
  assign outOfRange = (wordIdx >= WORD_LIMIT);
  assign reqErr     = outOfRange || misaligned || sizeBad;
  assign memWrEn    = accept && req_write && !reqErr;

  mem_lane_align u_laneAlign (
    .size       (req_size),
    .byteOfs    (req_addr[1:0]),
    .zeroExt    (req_unsigned),
    .storeData  (req_wdata),
    .memWord    (memWord),
    .byteEn     (byteEn),
    .laneData   (laneData),
    .loadData   (loadData),
    .misaligned (misaligned),
    .sizeBad    (sizeBad)
  );

  // Four independent byte-wide arrays; contents are never reset.
  for (genvar lane = 0; lane < 4; lane++) begin : gLane
    logic [7:0] mem [DEPTH];

    // Write this lane on the accepting edge when its strobe is set.
    always_ff @(posedge CLK) begin
      if (memWrEn && byteEn[lane]) begin
        mem[memIdx] <= laneData[8*lane +: 8];
      end
    end

    // Asynchronous read so a load right after a store sees the stored bytes.
    assign memWord[8*lane +: 8] = mem[memIdx];
  end

  // Output stage state register.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // Next state: fill on accept, drain when the response leaves with nothing behind it.
  always_comb begin
    stateNext = state;
    case (state)
      EMPTY: begin
        if (accept) begin
          stateNext = FULL;
        end
      end
      FULL: begin
        if (rsp_ready && !accept) begin
          stateNext = EMPTY;
        end
      end
      default: begin
        stateNext = EMPTY;
      end
    endcase
  end

  // Response payload is captured only on accept, so it holds steady while stalled.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else if (accept) begin
      rsp_error <= reqErr;
      rsp_rdata <= (reqErr || req_write) ? 32'd0 : loadData;
    end
  end

  // Count errored requests, sticking at the maximum.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      err_count <= 16'd0;
    end else if (accept && reqErr) begin
      err_count <= satInc(err_count);
    end
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
module tb_data_mem_pipe;
  import data_mem_pipe_pkg::*;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 32;
  localparam int NVEC   = 18;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [15:0] err_count;

  data_mem_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .err_count    (err_count)
  );

  always #5 CLK = ~CLK;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    bit          wr;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] expRd;
    bit          expErr;
    int          expCnt;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    bit          er;
  } rsp_t;

  vec_t        vecs [NVEC];
  rsp_t        expQ [$];
  logic [7:0]  mbytes [DEPTH*4];
  int unsigned modelErr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed array, errors and extension from plain arithmetic.
  function automatic void modelApply(input bit wr, input logic [1:0] sz, input bit uns,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output bit er);
    int unsigned     nb;
    longint unsigned v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || (a >= 32'(DEPTH*4)) || ((a % nb) != 0);
    rd = 32'd0;
    if (er) begin
      if (modelErr < 65535) modelErr++;
    end else if (wr) begin
      for (int unsigned i = 0; i < nb; i++) mbytes[a+i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int unsigned i = 0; i < nb; i++) v = v | (longint'(mbytes[a+i]) << (8*i));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
      rd = v[31:0];
    end
  endfunction

  task automatic setReq(input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  // One request with rsp_ready held high; returns what is seen one cycle after accept.
  task automatic doReq(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er, output bit seen);
    int waitCyc = 0;
    @(negedge CLK);
    setReq(wr, sz, uns, addr, wd);
    rsp_ready = 1'b1;
    #1;
    while (!req_ready && waitCyc < 20) begin
      @(negedge CLK);
      #1;
      waitCyc++;
    end
    @(negedge CLK);
    req_valid = 1'b0;
    #1;
    seen = rsp_valid;
    rd   = rsp_rdata;
    er   = rsp_error;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          er;
    bit          seen;
    int          initIdx;
    bit          pend;
    bit          hold;
    logic [31:0] holdRd;
    bit          holdEr;
    rsp_t        got;
    rsp_t        exp;

    vecs[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h10,             32'hDEADBEEF, 32'h00000000, 1'b0, 0};
    vecs[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,             32'h0,        32'hDEADBEEF, 1'b0, 0};
    vecs[2]  = '{1'b0, SZ_BYTE, 1'b0, 32'h13,             32'h0,        32'hFFFFFFDE, 1'b0, 0};
    vecs[3]  = '{1'b0, SZ_BYTE, 1'b1, 32'h13,             32'h0,        32'h000000DE, 1'b0, 0};
    vecs[4]  = '{1'b0, SZ_HALF, 1'b0, 32'h10,             32'h0,        32'hFFFFBEEF, 1'b0, 0};
    vecs[5]  = '{1'b1, SZ_BYTE, 1'b0, 32'h11,             32'hAAAAAA55, 32'h00000000, 1'b0, 0};
    vecs[6]  = '{1'b0, SZ_WORD, 1'b0, 32'h10,             32'h0,        32'hDEAD55EF, 1'b0, 0};
    vecs[7]  = '{1'b1, SZ_WORD, 1'b0, 32'h00,             32'hA5A5A5A5, 32'h00000000, 1'b0, 0};
    vecs[8]  = '{1'b1, SZ_HALF, 1'b0, 32'h01,             32'h00001234, 32'h00000000, 1'b1, 1};
    vecs[9]  = '{1'b1, SZ_WORD, 1'b0, 32'(DEPTH*4),       32'h12345678, 32'h00000000, 1'b1, 2};
    vecs[10] = '{1'b1, 2'b11,   1'b0, 32'h00,             32'hFFFFFFFF, 32'h00000000, 1'b1, 3};
    vecs[11] = '{1'b0, SZ_WORD, 1'b0, 32'h00,             32'h0,        32'hA5A5A5A5, 1'b0, 3};
    vecs[12] = '{1'b0, SZ_HALF, 1'b1, 32'h12,             32'h0,        32'h0000DEAD, 1'b0, 3};
    vecs[13] = '{1'b0, SZ_HALF, 1'b0, 32'h12,             32'h0,        32'hFFFFDEAD, 1'b0, 3};
    vecs[14] = '{1'b0, SZ_BYTE, 1'b0, 32'h11,             32'h0,        32'h00000055, 1'b0, 3};
    vecs[15] = '{1'b0, SZ_HALF, 1'b0, 32'h13,             32'h0,        32'h00000000, 1'b1, 4};
    vecs[16] = '{1'b0, SZ_WORD, 1'b0, 32'h12,             32'h0,        32'h00000000, 1'b1, 5};
    vecs[17] = '{1'b0, SZ_BYTE, 1'b0, 32'h80000000,       32'h0,        32'h00000000, 1'b1, 6};

    // Reset with a request presented: it must be ignored.
    RESET_N = 1'b0;
    rsp_ready = 1'b0;
    setReq(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0BADF00D);
    repeat (3) @(negedge CLK);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    req_valid = 1'b0;
    RESET_N = 1'b1;
    @(negedge CLK);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_idle_valid", 32'(rsp_valid), 32'd0);

    // Directed vector table.
    for (int i = 0; i < NVEC; i++) begin
      doReq(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, er, seen);
      check($sformatf("vec%0d_latency", i), 32'(seen), 32'd1);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
      check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].expErr));
      check($sformatf("vec%0d_errcnt", i), 32'(err_count), 32'(vecs[i].expCnt));
    end

    // Backpressure: A held for 3 cycles while B waits, then both flow in order.
    @(negedge CLK);
    rsp_ready = 1'b0;
    setReq(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    #1;
    check("bp_accept_a", 32'(req_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      setReq(1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0);
      #1;
      check($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'd0);
      check($sformatf("bp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
      check($sformatf("bp_rdata_c%0d", c), rsp_rdata, 32'hDEAD55EF);
    end
    @(negedge CLK);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd1);
    check("bp_a_rdata", rsp_rdata, 32'hDEAD55EF);
    @(negedge CLK);
    req_valid = 1'b0;
    #1;
    check("bp_b_valid", 32'(rsp_valid), 32'd1);
    check("bp_b_rdata", rsp_rdata, 32'hA5A5A5A5);
    @(negedge CLK);
    #1;
    check("bp_no_dup", 32'(rsp_valid), 32'd0);

    // Load issued the cycle right after a store to the same word.
    @(negedge CLK);
    setReq(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D);
    @(negedge CLK);
    setReq(1'b0, SZ_BYTE, 1'b0, 32'h22, 32'h0);
    #1;
    check("raw_store_rsp", rsp_rdata, 32'd0);
    check("raw_store_ready", 32'(req_ready), 32'd1);
    @(negedge CLK);
    req_valid = 1'b0;
    #1;
    check("raw_load_valid", 32'(rsp_valid), 32'd1);
    check("raw_load_rdata", rsp_rdata, 32'hFFFFFFFE);

    // Reset while a response is pending; a store presented during reset must not land.
    @(negedge CLK);
    rsp_ready = 1'b0;
    setReq(1'b0, SZ_WORD, 1'b0, 32'(DEPTH*4), 32'h0);
    @(negedge CLK);
    RESET_N = 1'b0;
    rsp_ready = 1'b1;
    setReq(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344);
    #1;
    check("mr_pending_valid", 32'(rsp_valid), 32'd1);
    check("mr_pending_err", 32'(rsp_error), 32'd1);
    check("mr_pending_cnt", 32'(err_count), 32'd7);
    @(negedge CLK);
    RESET_N = 1'b1;
    req_valid = 1'b0;
    #1;
    check("mr_valid_cleared", 32'(rsp_valid), 32'd0);
    check("mr_cnt_cleared", 32'(err_count), 32'd0);
    check("mr_ready", 32'(req_ready), 32'd1);
    doReq(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, rd, er, seen);
    check("mr_mem_kept", rd, 32'hDEAD55EF);
    check("mr_mem_err", 32'(er), 32'd0);

    // Randomized traffic against the reference model; every word is written first.
    modelErr = 0;
    initIdx = 0;
    pend = 1'b0;
    hold = 1'b0;
    holdRd = 32'd0;
    holdEr = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      if (!pend) begin
        if (initIdx < DEPTH) begin
          setReq(1'b1, SZ_WORD, 1'b0, 32'(initIdx*4), $urandom);
          initIdx++;
        end else if ($urandom_range(0, 3) != 0) begin
          req_valid    = 1'b1;
          req_write    = ($urandom_range(0, 9) < 4);
          req_size     = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          req_unsigned = 1'($urandom_range(0, 1));
          req_wdata    = $urandom;
          case ($urandom_range(0, 9))
            0:       req_addr = $urandom;
            1:       req_addr = 32'(DEPTH*4) + 32'($urandom_range(0, 15));
            default: req_addr = 32'($urandom_range(0, DEPTH*4-1));
          endcase
          if ($urandom_range(0, 9) < 7) begin
            if (req_size == SZ_HALF) req_addr[0] = 1'b0;
            if (req_size == SZ_WORD) req_addr[1:0] = 2'b00;
          end
        end else begin
          req_valid = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold) begin
        check("rnd_hold_valid", 32'(rsp_valid), 32'd1);
        check("rnd_hold_rdata", rsp_rdata, holdRd);
        check("rnd_hold_error", 32'(rsp_error), 32'(holdEr));
      end
      check("rnd_ready_rule", 32'(req_ready), 32'(!rsp_valid || rsp_ready));
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          check("rnd_spurious_rsp", 32'(expQ.size()), 32'd1);
        end else begin
          exp = expQ.pop_front();
          check("rnd_rdata", rsp_rdata, exp.rd);
          check("rnd_error", 32'(rsp_error), 32'(exp.er));
        end
      end
      hold   = rsp_valid && !rsp_ready;
      holdRd = rsp_rdata;
      holdEr = rsp_error;
      if (req_valid && req_ready) begin
        modelApply(req_write, req_size, req_unsigned, req_addr, req_wdata, got.rd, got.er);
        expQ.push_back(got);
        pend = 1'b0;
      end else begin
        pend = req_valid;
      end
    end

    // Drain outstanding responses.
    @(negedge CLK);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rsp_valid) begin
        if (expQ.size() == 0) begin
          check("drain_spurious_rsp", 32'(expQ.size()), 32'd1);
        end else begin
          exp = expQ.pop_front();
          check("drain_rdata", rsp_rdata, exp.rd);
          check("drain_error", 32'(rsp_error), 32'(exp.er));
        end
      end
      @(negedge CLK);
    end
    check("drain_lost_rsp", 32'(expQ.size()), 32'd0);
    check("rnd_err_count", 32'(err_count), 32'(modelErr));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
